// File: rtl/alu_muldiv_seq_if.sv
// Request/result and shared-ALU signal bundle between the EX stage and the
// multiply/divide sequencer.
interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            alu_own;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [4:0]      alu_ctl;
    logic            alu_sign;
    logic [XLEN-1:0] alu_out;

    modport master (
        output start, op, a, b, flush, alu_out,
        input  busy, done, hi, lo, alu_own, alu_in1, alu_in2, alu_ctl, alu_sign
    );

    modport slave (
        input  start, op, a, b, flush, alu_out,
        output busy, done, hi, lo, alu_own, alu_in1, alu_in2, alu_ctl, alu_sign
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Radix-2 MULT/MULTU/DIV/DIVU sequencer producing HI/LO with a fixed 35-cycle
// latency, borrowing the shared EX-stage ALU for one add/sub per iteration.
module alu_muldiv_seq #(
    parameter int         XLEN    = 32,
    parameter int         ITERS   = 32,
    parameter logic [4:0] ALU_ADD = 5'b00010,
    parameter logic [4:0] ALU_SUB = 5'b00110,
    parameter logic [4:0] ALU_NOP = 5'b11111
) (
    input  logic           clk,
    input  logic           reset_n,
    alu_muldiv_seq_if.slave bus
);
    localparam int               CNT_W    = $clog2(ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES_W   = {XLEN{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [XLEN-1:0] abs_w(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? neg_w(v) : v;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [XLEN-1:0]  a_r, b_r, p_r, q_r, d_r, hi_r, lo_r;
    logic             sa_r, sb_r, busy_r, done_r, own_r;

    logic [XLEN-1:0]   r_shift_s, step_p_s, step_q_s, mul_sum_s;
    logic              mul_c_s;
    logic [XLEN-1:0]   alu_in1_s, alu_in2_s, fix_hi_s, fix_lo_s;
    logic [4:0]        alu_ctl_s;
    logic [2*XLEN-1:0] prod_neg_s;

    assign r_shift_s  = {p_r[XLEN-2:0], q_r[XLEN-1]};
    assign prod_neg_s = neg_dw({p_r, q_r});

    // ALU operand mux and the single-iteration shift-add / restoring-subtract step
    always_comb begin
        alu_in1_s = ZERO_W;
        alu_in2_s = ZERO_W;
        alu_ctl_s = ALU_NOP;
        step_p_s  = p_r;
        step_q_s  = q_r;
        mul_sum_s = p_r;
        mul_c_s   = 1'b0;
        if (own_r) begin
            if (op_r[1]) begin
                alu_in1_s = r_shift_s;
                alu_in2_s = d_r;
                alu_ctl_s = ALU_SUB;
                // hb covers the 33-bit partial remainder that no longer fits in P
                if (p_r[XLEN-1] || (r_shift_s >= d_r)) begin
                    step_p_s = bus.alu_out;
                    step_q_s = {q_r[XLEN-2:0], 1'b1};
                end else begin
                    step_p_s = r_shift_s;
                    step_q_s = {q_r[XLEN-2:0], 1'b0};
                end
            end else begin
                alu_in1_s = p_r;
                alu_in2_s = d_r;
                alu_ctl_s = ALU_ADD;
                if (q_r[0]) begin
                    mul_sum_s = bus.alu_out;
                    mul_c_s   = (bus.alu_out < p_r);
                end else begin
                    mul_sum_s = p_r;
                    mul_c_s   = 1'b0;
                end
                step_p_s = {mul_c_s, mul_sum_s[XLEN-1:1]};
                step_q_s = {mul_sum_s[0], q_r[XLEN-1:1]};
            end
        end else begin
            alu_ctl_s = ALU_NOP;
        end
    end

    // Sign fix-up of magnitudes; divide-by-zero returns the raw dividend and all-ones
    always_comb begin
        fix_hi_s = p_r;
        fix_lo_s = q_r;
        if (op_r[1]) begin
            if (d_r == ZERO_W) begin
                fix_hi_s = a_r;
                fix_lo_s = ONES_W;
            end else begin
                fix_hi_s = sa_r ? neg_w(p_r) : p_r;
                fix_lo_s = (sa_r ^ sb_r) ? neg_w(q_r) : q_r;
            end
        end else if (sa_r ^ sb_r) begin
            {fix_hi_s, fix_lo_s} = prod_neg_s;
        end else begin
            fix_hi_s = p_r;
            fix_lo_s = q_r;
        end
    end

    // Sequencer FSM with datapath registers and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 2'b00;
            a_r     <= ZERO_W;
            b_r     <= ZERO_W;
            p_r     <= ZERO_W;
            q_r     <= ZERO_W;
            d_r     <= ZERO_W;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            own_r   <= 1'b0;
        end else if (bus.flush) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            own_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op_r    <= bus.op;
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        busy_r  <= 1'b1;
                        state_r <= S_PREP;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_PREP: begin
                    sa_r    <= op_r[0] & a_r[XLEN-1];
                    sb_r    <= op_r[0] & b_r[XLEN-1];
                    p_r     <= ZERO_W;
                    q_r     <= abs_w(a_r, op_r[0]);
                    d_r     <= abs_w(b_r, op_r[0]);
                    cnt_r   <= {CNT_W{1'b0}};
                    own_r   <= 1'b1;
                    state_r <= S_ITER;
                end
                S_ITER: begin
                    p_r   <= step_p_s;
                    q_r   <= step_q_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        own_r   <= 1'b0;
                        state_r <= S_FIX;
                    end else begin
                        state_r <= S_ITER;
                    end
                end
                S_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    own_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.alu_own  = own_r;
    assign bus.alu_in1  = alu_in1_s;
    assign bus.alu_in2  = alu_in2_s;
    assign bus.alu_ctl  = alu_ctl_s;
    assign bus.alu_sign = 1'b0;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed vector table, randomized ops
// against a plain-arithmetic reference, and flush / restart / async-reset sequences.
module tb_alu_muldiv_seq;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    alu_muldiv_seq_if #(.XLEN(32)) bus ();

    alu_muldiv_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU as seen by the EX stage
    always_comb begin
        case (bus.alu_ctl)
            5'b00010: bus.alu_out = bus.alu_in1 + bus.alu_in2;
            5'b00110: bus.alu_out = bus.alu_in1 - bus.alu_in2;
            default:  bus.alu_out = 32'h0;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: {hi,lo} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = {32'h0, a} * {32'h0, b};
            2'b01: res = 64'(sa * sb);
            default: begin
                if (b == 32'h0) begin
                    res = {a, 32'hFFFFFFFF};
                end else if (op == 2'b10) begin
                    res = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int flush_at, input int restart_at,
                          output int done_idx, output int done_cnt, output int own_cnt,
                          output int busy_cnt, output logic [31:0] hi_o, output logic [31:0] lo_o);
        done_idx = 0; done_cnt = 0; own_cnt = 0; busy_cnt = 0;
        hi_o = 32'h0; lo_o = 32'h0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op_i; bus.a = a_i; bus.b = b_i;
        @(posedge clk);
        for (int idx = 1; idx <= 45; idx++) begin
            if (idx > 1) @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.flush = 1'b0;
            bus.a = $urandom;
            bus.b = $urandom;
            if (bus.alu_own) own_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_idx == 0) begin
                    done_idx = idx;
                    hi_o = bus.hi;
                    lo_o = bus.lo;
                end
            end
            if (idx == restart_at) begin
                bus.start = 1'b1;
                bus.op = 2'($urandom_range(0, 3));
            end
            if (idx == flush_at) bus.flush = 1'b1;
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] op_i, input logic [31:0] a_i,
                            input logic [31:0] b_i, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input int restart_at);
        int done_idx, done_cnt, own_cnt, busy_cnt;
        logic [31:0] hi_v, lo_v;
        run_op(op_i, a_i, b_i, 0, restart_at, done_idx, done_cnt, own_cnt, busy_cnt, hi_v, lo_v);
        check({name, "_latency"}, 64'(done_idx), 64'd35);
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, "_own_cycles"}, 64'(own_cnt), 64'd32);
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd35);
        check({name, "_hi"}, {32'h0, hi_v}, {32'h0, exp_hi});
        check({name, "_lo"}, {32'h0, lo_v}, {32'h0, exp_lo});
    endtask

    initial begin
        int done_idx, done_cnt, own_cnt, busy_cnt;
        logic [31:0] hi_v, lo_v, ra, rb;
        logic [1:0]  rop;
        logic [63:0] exp;

        checks = 0;
        failures = 0;
        vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4] = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6] = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[7] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        check("rst_done", {63'h0, bus.done}, 64'h0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        check("rst_own", {63'h0, bus.alu_own}, 64'h0);
        check("rst_ctl", {59'h0, bus.alu_ctl}, 64'h1F);
        check("rst_ops", {bus.alu_in1, bus.alu_in2}, 64'h0);
        check("rst_sign", {63'h0, bus.alu_sign}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].hi, vecs[i].lo, 0);
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h80000000;
                default: rb = $urandom;
            endcase
            exp = ref_model(rop, ra, rb);
            check_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, exp[63:32], exp[31:0], 0);
        end

        // Second start mid-operation must be ignored
        check_op("restart", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 10);

        // Flush mid-operation: no done, busy drops next cycle, hi/lo retained
        run_op(2'b00, 32'h0000DEAD, 32'h0000BEEF, 20, 0,
               done_idx, done_cnt, own_cnt, busy_cnt, hi_v, lo_v);
        check("flush_done_cnt", 64'(done_cnt), 64'd0);
        check("flush_busy_cycles", 64'(busy_cnt), 64'd20);
        check("flush_hilo_kept", {bus.hi, bus.lo}, {32'd2, 32'd14});

        // Flush beats start in IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_idle_busy", {63'h0, bus.busy}, 64'h0);
        @(posedge clk);
        #1;
        check("flush_start_idle_busy2", {63'h0, bus.busy}, 64'h0);

        // Asynchronous reset between edges during ITER
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("pre_reset_own", {63'h0, bus.alu_own}, 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_busy", {63'h0, bus.busy}, 64'h0);
        check("areset_hilo", {bus.hi, bus.lo}, 64'h0);
        check("areset_own", {63'h0, bus.alu_own}, 64'h0);
        check("areset_ctl", {59'h0, bus.alu_ctl}, 64'h1F);
        @(negedge clk);
        reset_n = 1'b1;
        check_op("post_reset", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that computes MULT/MULTU/DIV/DIVU results into HI/LO.
- Borrows the shared 32-bit ALU for one add or subtract per iteration (radix-2, 32 iterations).
- Sits beside the EX stage. While it owns the ALU, the EX-stage mux selects the sequencer's ALU operand/control outputs (`alu_own`=1) and the pipeline stalls on `busy`.

Parameters:
- `XLEN`, 32, operand width. Only 32 is supported.
- `ITERS`, 32, iteration count. Must equal `XLEN`.
- `ALU_ADD`, 5'b00010, ALU control code for add.
- `ALU_SUB`, 5'b00110, ALU control code for subtract.
- `ALU_NOP`, 5'b11111, ALU control code forcing a zero output.

Ports:
- `clk` in 1: the single clock. Everything is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse. Sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in 32: multiplicand or dividend.
- `b` in 32: multiplier or divisor.
- `flush` in 1: synchronous abort.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `hi` out 32: MULT high word, or DIV remainder.
- `lo` out 32: MULT low word, or DIV quotient.
- `alu_own` out 1: high while in ITER.
- `alu_in1` out 32: ALU operand 1.
- `alu_in2` out 32: ALU operand 2.
- `alu_ctl` out 5: ALU control.
- `alu_sign` out 1: always 0.
- `alu_out` in 32: combinational ALU result.

Behaviour:
- Reset (`reset_n`=0, asynchronous, including mid-operation):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, `alu_own`=0.
  - `alu_in1`=0, `alu_in2`=0, `alu_ctl`=`ALU_NOP`, `alu_sign`=0.
  - All internal registers clear.
- States: IDLE -> PREP -> ITER (32 cycles) -> FIX -> DONE -> IDLE.
- IDLE:
  - If `start`=1 at edge T: latch `op`, `a`, `b` and go to PREP. `busy`=1 from T+1.
  - `start` is ignored in every other state. There is no queueing.
- PREP (T+1):
  - Signed ops (`op[0]`=1): store |a| and |b| using internal two's-complement negate. Store sa=`a[31]`, sb=`b[31]`.
  - Unsigned ops: store a and b unchanged.
  - Initialise: counter=0, P=0, Q=|a|, D=|b|.
- ITER (T+2 .. T+33, exactly 32 cycles):
  - `alu_own`=1 in every ITER cycle and only in ITER.
  - ALU operands are driven combinationally from registers. The result is consumed at the same edge.
- Multiply step (shift-add):
  - `alu_in1`=P, `alu_in2`=D, `alu_ctl`=`ALU_ADD`.
  - If `Q[0]`=1: s=`alu_out`, c=(`alu_out` < P unsigned).
  - Else: s=P, c=0.
  - Update: {P,Q} <= {c,s,Q[31:1]}.
- Divide step (restoring):
  - R'={P[30:0],Q[31]}, hb=`P[31]`.
  - `alu_in1`=R', `alu_in2`=D, `alu_ctl`=`ALU_SUB`.
  - If hb=1 or R' >= D (unsigned): P <= `alu_out`, Q <= {Q[30:0],1}.
  - Else: P <= R', Q <= {Q[30:0],0}.
- ALU outputs outside ITER: `alu_ctl`=`ALU_NOP`, operands 0.
- FIX (T+34):
  - MULT with sa^sb=1: {P,Q} <= 64-bit two's-complement negate.
  - DIV: quotient negated if sa^sb; remainder negated if sa.
  - Unsigned ops: no change.
- DONE (T+35):
  - `hi`/`lo` registers load from P/Q at the FIX->DONE edge, so they are visible during DONE.
  - `done`=1 for exactly this cycle, `busy`=1.
  - Next cycle: IDLE, `busy`=0.
  - `hi`/`lo` hold until the next DONE. They are not cleared by `start`.
- Latency: fixed at 35 cycles from the `start` edge to the `done` cycle, for all ops and operand values.
- Divide by zero (`b`=0, DIVU or DIV):
  - Full latency is still used.
  - Result: `hi`=`a` as given, `lo`=32'hFFFFFFFF (no sign fix).
- Signed special case: DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This is natural wrap; no exception.
- Flush:
  - `flush`=1 in any non-IDLE state: next state IDLE, no `done` pulse, `hi`/`lo` unchanged.
  - If `flush` and `start` are both 1 in IDLE, `flush` wins and the request is dropped.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` exactly 35 cycles after `start`; `hi`=0xFFFFFFFE, `lo`=0x00000001; `alu_own` high for exactly 32 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). DIVU a=100, b=7 -> `lo`=14, `hi`=2.
- DIVU a=0x12345678, b=0 -> `hi`=0x12345678, `lo`=0xFFFFFFFF, latency 35.
- Second `start` pulsed at T+10 during an op -> ignored, exactly one `done`. `flush` at T+20 -> `busy`=0 at T+21, no `done`, `hi`/`lo` keep previous values.
- `reset_n` low at T+15 (asynchronous, between edges) -> `busy`, `hi`, `lo`, `alu_own` go to 0 immediately and `alu_ctl`=11111. After release, a new MULTU 3×5 gives `lo`=15, `hi`=0.
